// File: rtl/piso_tx_pkg.sv
// Shared definitions for the serial shift-register link (transmitter,
// receiver and their benches).
//   piso_state_e        : FSM state encodings ST_IDLE / ST_SHIFT / ST_PARITY
//   PISO_DEFAULT_WIDTH  : default data word width
package piso_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } piso_state_e;

  localparam int unsigned PISO_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in serial-out transmitter for the shift-register link.
// Takes one WIDTH-bit word over a valid/ready handshake and sends it one bit
// per clock, marking the frame with ser_valid / frame_start / done. Words can
// stream back to back with no idle cycle in between.
//
// Ports:
//   clk          in   clock, all state on posedge
//   reset_n      in   asynchronous active-low reset
//   load_valid   in   load_data valid this cycle
//   load_ready   out  word accepted this cycle if load_valid is high
//   load_data    in   WIDTH-bit parallel word
//   ser_out      out  serial data bit (registered)
//   ser_valid    out  ser_out carries a frame bit (registered)
//   frame_start  out  first bit of a frame (registered)
//   done         out  final bit of a frame (registered)
//
// Build option: define PISO_PARITY_EN to append an even-parity bit to every
// frame; done then marks the parity cycle instead of the last data bit.
module piso_shift_tx
  import piso_tx_pkg::*;
#(
  parameter int unsigned WIDTH     = PISO_DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int unsigned    CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_PEN  = CW'(WIDTH - 1);

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             done_q, done_d;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic last_data;
  logic last_cycle;
  logic accept;

  // State and counter describe the bit currently on ser_out; cnt_q is the
  // number of data bits of this frame already presented (1..WIDTH).
  assign last_data = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);

`ifdef PISO_PARITY_EN
  assign last_cycle = (state_q == ST_PARITY);
`else
  assign last_cycle = last_data;
`endif

  assign load_ready = reset_n & ((state_q == ST_IDLE) | last_cycle);
  assign accept     = load_valid & load_ready;

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    ser_out_d     = 1'b0;
    ser_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    done_d        = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d      = parity_q;
`endif

    if (accept) begin
      // First bit goes straight to the output register, so the shift
      // register only keeps the bits still to be sent.
      state_d       = ST_SHIFT;
      cnt_d         = CW'(1);
      ser_valid_d   = 1'b1;
      frame_start_d = 1'b1;
      if (MSB_FIRST) begin
        ser_out_d = load_data[WIDTH-1];
        shreg_d   = load_data << 1;
      end else begin
        ser_out_d = load_data[0];
        shreg_d   = load_data >> 1;
      end
`ifdef PISO_PARITY_EN
      parity_d = ^load_data;
`endif
    end else begin
      unique case (state_q)
        ST_SHIFT: begin
          if (!last_data) begin
            ser_valid_d = 1'b1;
            cnt_d       = cnt_q + CW'(1);
            if (MSB_FIRST) begin
              ser_out_d = shreg_q[WIDTH-1];
              shreg_d   = shreg_q << 1;
            end else begin
              ser_out_d = shreg_q[0];
              shreg_d   = shreg_q >> 1;
            end
`ifndef PISO_PARITY_EN
            done_d = (cnt_q == CNT_PEN);
`endif
          end else begin
`ifdef PISO_PARITY_EN
            state_d     = ST_PARITY;
            ser_out_d   = parity_q;
            ser_valid_d = 1'b1;
            done_d      = 1'b1;
`else
            state_d = ST_IDLE;
`endif
          end
        end
        ST_PARITY: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      shreg_q       <= '0;
      cnt_q         <= '0;
      ser_out_q     <= 1'b0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      done_q        <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      ser_out_q     <= ser_out_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
      done_q        <= done_d;
`ifdef PISO_PARITY_EN
      parity_q      <= parity_d;
`endif
    end
  end

  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign frame_start = frame_start_q;
  assign done        = done_q;

endmodule
